// File: rtl/instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_decode
// Description : Fetch/decode front end. It fetches one word per PC from a
//               combinational instruction memory, registers the decoded fields,
//               and hands them to execute over a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_decode #(
    parameter int START_PC = 0,
    parameter int LAST_PC  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  pc,
    input  logic [31:0] instruction,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  opcode,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [15:0] imm,
    output logic        is_imm,
    output logic        illegal,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_ISSUE = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [4:0] c_START_PC = 5'(START_PC);
    localparam logic [4:0] c_LAST_PC  = 5'(LAST_PC);
    localparam logic [4:0] c_PC_MAX   = 5'd31;

    localparam logic [2:0] c_OP_ADD    = 3'b010;
    localparam logic [2:0] c_OP_SHIFTL = 3'b100;
    localparam logic [2:0] c_OP_ADDI   = 3'b110;
    localparam logic [2:0] c_OP_SUBI   = 3'b111;

    logic [1:0]  r_state;
    logic [4:0]  r_pc;
    logic        r_out_valid;
    logic [2:0]  r_opcode;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [15:0] r_imm;
    logic        r_is_imm;
    logic        r_illegal;
    logic        r_busy;
    logic        r_done;

    logic [2:0]  w_opcode;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [15:0] w_imm;
    logic        w_is_imm;
    logic        w_illegal;
    logic        w_last;

    // Field extraction; unsupported opcodes keep only the opcode field.
    always_comb begin
        w_opcode  = instruction[31:29];
        w_rs1     = '0;
        w_rs2     = '0;
        w_rd      = '0;
        w_imm     = '0;
        w_is_imm  = 1'b0;
        w_illegal = 1'b0;
        case (instruction[31:29])
            c_OP_ADD, c_OP_SHIFTL: begin
                w_rs1 = instruction[28:24];
                w_rs2 = instruction[23:19];
                w_rd  = instruction[18:14];
            end
            c_OP_ADDI, c_OP_SUBI: begin
                w_rs1    = instruction[28:24];
                w_rd     = instruction[23:19];
                w_imm    = instruction[15:0];
                w_is_imm = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // The run ends on a trap, on the last programmed PC, or at the top of the
    // address space so the PC never wraps back to zero.
    assign w_last = r_illegal || (r_pc == c_LAST_PC) || (r_pc == c_PC_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_pc        <= c_START_PC;
            r_out_valid <= 1'b0;
            r_opcode    <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_imm       <= '0;
            r_is_imm    <= 1'b0;
            r_illegal   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: begin
                    if (start) begin
                        r_state <= c_ST_FETCH;
                        r_pc    <= c_START_PC;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                c_ST_FETCH: begin
                    r_opcode    <= w_opcode;
                    r_rs1       <= w_rs1;
                    r_rs2       <= w_rs2;
                    r_rd        <= w_rd;
                    r_imm       <= w_imm;
                    r_is_imm    <= w_is_imm;
                    r_illegal   <= w_illegal;
                    r_out_valid <= 1'b1;
                    r_state     <= c_ST_ISSUE;
                end
                c_ST_ISSUE: begin
                    // out_valid is always high here, so out_ready alone
                    // completes the handshake.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last) begin
                            r_state <= c_ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_pc    <= r_pc + 5'd1;
                            r_state <= c_ST_FETCH;
                        end
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign pc        = r_pc;
    assign out_valid = r_out_valid;
    assign opcode    = r_opcode;
    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign rd        = r_rd;
    assign imm       = r_imm;
    assign is_imm    = r_is_imm;
    assign illegal   = r_illegal;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_decode
// Description : Scoreboard bench for instr_fetch_decode with a program-level
//               reference model and randomized backpressure and programs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_decode;

    localparam int c_START_PC = 0;
    localparam int c_LAST_PC  = 5;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [15:0] imm;
        logic        is_imm;
        logic        illegal;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  pc;
    logic [31:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  opcode;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic        is_imm;
    logic        illegal;
    logic        busy;
    logic        done;

    logic [31:0] mem [0:31];
    dec_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          final_pc;

    assign instruction = mem[pc];

    instr_fetch_decode #(.START_PC(c_START_PC), .LAST_PC(c_LAST_PC)) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc), .instruction(instruction),
        .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .is_imm(is_imm),
        .illegal(illegal), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [2:0] op, input logic [4:0] s1,
                                          input logic [4:0] s2, input logic [4:0] d);
        return {op, s1, s2, d, 14'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [2:0] op, input logic [4:0] s1,
                                          input logic [4:0] d, input logic [15:0] im);
        return {op, s1, d, 3'd0, im};
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] w);
        dec_t d;
        d        = '0;
        d.opcode = w[31:29];
        if (d.opcode == 3'b010 || d.opcode == 3'b100) begin
            d.rs1 = w[28:24];
            d.rs2 = w[23:19];
            d.rd  = w[18:14];
        end else if (d.opcode == 3'b110 || d.opcode == 3'b111) begin
            d.rs1    = w[28:24];
            d.rd     = w[23:19];
            d.imm    = w[15:0];
            d.is_imm = 1'b1;
        end else begin
            d.illegal = 1'b1;
        end
        return d;
    endfunction

    // Walk the program the way the spec describes a run and queue every issue.
    task automatic expect_run();
        dec_t d;
        for (int p = c_START_PC; p < 32; p++) begin
            d = ref_decode(mem[p]);
            exp_q.push_back(d);
            if (d.illegal || p == c_LAST_PC || p == 31) begin
                final_pc = p;
                break;
            end
        end
    endtask

    always @(negedge clk) begin
        dec_t e;
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got opcode %0h with empty scoreboard", opcode);
            end else begin
                e = exp_q[0];
                chk("issue_fields", {opcode, rs1, rs2, rd, imm, is_imm, illegal}, e);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready held high, 1: stall 4 cycles at pc 2, 2: random ready/start
    task automatic run(input int mode);
        int n = 0;
        int first_valid = -1;
        int stall = 0;
        bit finished = 0;
        expect_run();
        start     = 1'b1;
        out_ready = 1'b1;
        while (n < 200) begin
            step();
            n++;
            start = 1'b0;
            if (out_valid && first_valid < 0) first_valid = n;
            if (done) begin
                finished = 1;
                break;
            end
            if (mode == 1 && pc == 5'd2 && out_valid && stall < 4) begin
                out_ready = 1'b0;
                stall++;
                chk("stall_pc", pc, 2);
            end else if (mode == 2) begin
                out_ready = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 7) == 0) start = 1'b1;
            end else begin
                out_ready = 1'b1;
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL run_timeout: got no done after %0d cycles, required done", n);
        end
        out_ready = 1'b0;
        chk("done_flag", done, 1);
        chk("done_pc", pc, final_pc);
        chk("done_valid", out_valid, 0);
        chk("done_busy", busy, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
        if (mode == 0) begin
            chk("first_valid_latency", first_valid, 2);
            chk("run_cycles", n, 2 * (final_pc - c_START_PC + 1) + 1);
        end
    endtask

    task automatic load_plan_program();
        for (int i = 0; i < 32; i++) mem[i] = 32'hE000_0000;
        mem[0] = enc_i(3'b110, 5'd0, 5'd10, 16'd10);
        mem[1] = enc_i(3'b110, 5'd0, 5'd15, 16'd15);
        mem[2] = enc_r(3'b010, 5'd10, 5'd15, 5'd25);
        mem[3] = enc_i(3'b111, 5'd25, 5'd20, 16'd5);
        mem[4] = enc_i(3'b110, 5'd0, 5'd5, 16'd2);
        mem[5] = enc_r(3'b100, 5'd25, 5'd5, 5'd30);
    endtask

    initial begin
        logic [2:0] ops[8];
        int n;
        ops = '{3'b010, 3'b100, 3'b110, 3'b111, 3'b010, 3'b110, 3'b111, 3'b100};
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        load_plan_program();
        step(); step();
        rst = 1'b0;
        chk("reset_pc", pc, 0);
        chk("reset_valid", out_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_fields", {opcode, rs1, rs2, rd, imm, is_imm, illegal}, 0);

        run(0);
        run(1);

        mem[1] = 32'h0000_0000;
        run(0);
        load_plan_program();

        // Reset while the pc=3 instruction is being held.
        expect_run();
        start = 1'b1;
        out_ready = 1'b1;
        n = 0;
        while (!(pc == 5'd3 && out_valid) && n < 100) begin
            step();
            start = 1'b0;
            n++;
        end
        chk("reached_pc3", {pc, out_valid}, {5'd3, 1'b1});
        rst = 1'b1;
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        exp_q.delete();
        chk("midrst_pc", pc, 0);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_busy_done", {busy, done}, 0);
        chk("midrst_fields", {opcode, rs1, rs2, rd, imm, is_imm, illegal}, 0);
        step();
        chk("idle_stays", {out_valid, busy}, 0);

        run(0);
        run(0);

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] = $urandom;
                mem[i][31:29] = ($urandom_range(0, 9) == 0) ? 3'b011 : ops[$urandom_range(0, 7)];
            end
            run(2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
